aes_256_req_scheduler: RTL and testbench

//  Round-robin scheduler sharing one fully pipelined AES-256 core (one block/cycle, fixed LATENCY) among
//  NUM_REQ requesters. Sits in front of the core: selects one request per cycle, drives core STATE/KEY,
//  and tracks each in-flight block with a tag pipe, returning ciphertext with requester ID on exit.

---
 rtl/aes_sched_pkg.sv | 20 ++
 rtl/aes_256_req_scheduler_rr_arbiter.sv | 43 ++++
 rtl/aes_256_req_scheduler.sv | 142 ++++++++++++++
 tb/tb_aes_256_req_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sched_pkg.sv
// Shared widths, FSM encoding and tag format for the AES-256 request scheduler.
package aes_sched_pkg;

    localparam int unsigned AES_BLK_W = 128;
    localparam int unsigned AES_KEY_W = 256;
    // Tag ID field is sized for the largest supported requester count (16).
    localparam int unsigned TAG_ID_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_e;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/aes_256_req_scheduler_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner, grant is one-hot or zero.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_enable,
    input  logic [N-1:0]  i_req,
    output logic [N-1:0]  o_grant_c,
    output logic [IW-1:0] o_grant_id_c
);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_idx;
    logic          w_found;

    // Rotating priority search beginning at r_ptr+1
    always_comb begin
        o_grant_c    = '0;
        o_grant_id_c = '0;
        w_idx        = '0;
        w_found      = 1'b0;
        for (int k = 1; k <= int'(N); k++) begin
            w_idx = IW'((int'(r_ptr) + k) % int'(N));
            if (i_enable && !w_found && i_req[w_idx]) begin
                o_grant_c[w_idx] = 1'b1;
                o_grant_id_c     = w_idx;
                w_found          = 1'b1;
            end
        end
    end

    // Pointer follows the last winner; reset makes requester 0 the first candidate
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= IW'(N - 1);
        end else if (|o_grant_c) begin
            r_ptr <= o_grant_id_c;
        end
    end

endmodule

// File: rtl/aes_256_req_scheduler.sv
// Shares one fixed-latency AES-256 pipeline among NUM_REQ requesters and tags
// every launched block so the result returns with its owner's ID.
module aes_256_req_scheduler
    import aes_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned LATENCY = 108,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned CNT_W   = 7
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           ENABLE,
    input  logic [NUM_REQ-1:0]             REQ_VALID,
    output logic [NUM_REQ-1:0]             REQ_READY,
    input  logic [NUM_REQ*AES_BLK_W-1:0]   REQ_STATE,
    input  logic [NUM_REQ*AES_KEY_W-1:0]   REQ_KEY,
    output logic [AES_BLK_W-1:0]           AES_STATE,
    output logic [AES_KEY_W-1:0]           AES_KEY,
    input  logic [AES_BLK_W-1:0]           AES_OUT,
    output logic                           RSP_VALID,
    output logic [ID_W-1:0]                RSP_ID,
    output logic [AES_BLK_W-1:0]           RSP_DATA,
    output logic [CNT_W-1:0]               IN_FLIGHT,
    output logic                           IDLE
);

    state_e                 r_state;
    state_e                 w_next;
    logic                   w_grant_en;
    logic [NUM_REQ-1:0]     w_grant;
    logic [ID_W-1:0]        w_grant_id;
    logic                   w_hs;
    tag_t                   w_tag_in;
    tag_t                   r_tag [LATENCY];
    logic [AES_BLK_W-1:0]   r_aes_state;
    logic [AES_KEY_W-1:0]   r_aes_key;
    logic                   r_rsp_valid;
    logic [ID_W-1:0]        r_rsp_id;
    logic [CNT_W-1:0]       r_in_flight;
    logic                   r_idle;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .i_clk        (CLK),
        .i_rst        (RST),
        .i_enable     (w_grant_en),
        .i_req        (REQ_VALID),
        .o_grant_c    (w_grant),
        .o_grant_id_c (w_grant_id)
    );

    assign REQ_READY = w_grant;
    assign w_hs      = |(REQ_VALID & w_grant);
    assign w_tag_in  = '{valid: w_hs, id: w_hs ? TAG_ID_W'(w_grant_id) : '0};

    // Next-state logic; granting only while RUN and ENABLE both hold
    always_comb begin
        w_next     = r_state;
        w_grant_en = 1'b0;
        case (r_state)
            S_IDLE:  if (ENABLE) w_next = S_RUN;
            S_RUN: begin
                w_grant_en = ENABLE;
                if (!ENABLE) w_next = (r_in_flight != '0) ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                if (ENABLE)                  w_next = S_RUN;
                else if (r_in_flight == '0)  w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register and registered IDLE flag
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_idle  <= 1'b1;
        end else begin
            r_state <= w_next;
            r_idle  <= (w_next == S_IDLE);
        end
    end

    // Launch registers feeding the core; zero on bubble cycles
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_aes_state <= '0;
            r_aes_key   <= '0;
        end else if (w_hs) begin
            r_aes_state <= REQ_STATE[AES_BLK_W*w_grant_id +: AES_BLK_W];
            r_aes_key   <= REQ_KEY[AES_KEY_W*w_grant_id +: AES_KEY_W];
        end else begin
            r_aes_state <= '0;
            r_aes_key   <= '0;
        end
    end

    // Tag shift register tracking ownership of each core pipeline slot
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < int'(LATENCY); i++) r_tag[i] <= '0;
        end else begin
            r_tag[0] <= w_tag_in;
            for (int i = 1; i < int'(LATENCY); i++) r_tag[i] <= r_tag[i-1];
        end
    end

    // Response qualifier lines up with the core result on AES_OUT
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
        end else begin
            r_rsp_valid <= r_tag[LATENCY-1].valid;
            r_rsp_id    <= ID_W'(r_tag[LATENCY-1].id);
        end
    end

    // In-flight counter: launch increments, response decrements
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_in_flight <= '0;
        end else if (w_hs && !r_rsp_valid) begin
            r_in_flight <= r_in_flight + CNT_W'(1);
        end else if (!w_hs && r_rsp_valid) begin
            r_in_flight <= r_in_flight - CNT_W'(1);
        end
    end

    assign AES_STATE = r_aes_state;
    assign AES_KEY   = r_aes_key;
    assign RSP_VALID = r_rsp_valid;
    assign RSP_ID    = r_rsp_id;
    assign RSP_DATA  = AES_OUT;
    assign IN_FLIGHT = r_in_flight;
    assign IDLE      = r_idle;

endmodule

// File: tb/tb_aes_256_req_scheduler.sv
// Bench for aes_256_req_scheduler with a behavioural fixed-latency stand-in core.
module tb_aes_256_req_scheduler;
    import aes_sched_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned LAT  = 108;
    localparam int unsigned IDW  = 2;
    localparam int unsigned CW   = 7;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic                 ENABLE;
    logic [NREQ-1:0]      REQ_VALID;
    logic [NREQ-1:0]      REQ_READY;
    logic [NREQ*128-1:0]  REQ_STATE;
    logic [NREQ*256-1:0]  REQ_KEY;
    logic [127:0]         AES_STATE;
    logic [255:0]         AES_KEY;
    logic [127:0]         AES_OUT;
    logic                 RSP_VALID;
    logic [IDW-1:0]       RSP_ID;
    logic [127:0]         RSP_DATA;
    logic [CW-1:0]        IN_FLIGHT;
    logic                 IDLE;

    aes_256_req_scheduler #(
        .NUM_REQ (NREQ), .LATENCY (LAT), .ID_W (IDW), .CNT_W (CW)
    ) dut (
        .CLK (CLK), .RST (RST), .ENABLE (ENABLE),
        .REQ_VALID (REQ_VALID), .REQ_READY (REQ_READY),
        .REQ_STATE (REQ_STATE), .REQ_KEY (REQ_KEY),
        .AES_STATE (AES_STATE), .AES_KEY (AES_KEY), .AES_OUT (AES_OUT),
        .RSP_VALID (RSP_VALID), .RSP_ID (RSP_ID), .RSP_DATA (RSP_DATA),
        .IN_FLIGHT (IN_FLIGHT), .IDLE (IDLE)
    );

    always #5 CLK = ~CLK;

    // Stand-in cipher: any keyed, asymmetric mix is enough to tie data to its launch.
    function automatic logic [127:0] fake_enc(input logic [127:0] s, input logic [255:0] k);
        return (s ^ k[127:0]) + {k[191:128], k[255:192]};
    endfunction

    // Core model: samples AES_STATE/AES_KEY each edge, result LAT edges later.
    logic [127:0] core_pipe [LAT];
    always @(posedge CLK) begin
        core_pipe[0] <= fake_enc(AES_STATE, AES_KEY);
        for (int i = 1; i < int'(LAT); i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign AES_OUT = core_pipe[LAT-1];

    typedef struct {
        logic [IDW-1:0] id;
        logic [127:0]   data;
        int             due;
    } exp_t;

    typedef struct {
        logic [NREQ-1:0] mask;
        logic [NREQ-1:0] grant;
    } vec_t;

    exp_t sbq[$];
    exp_t e_new, e_cur;
    int   glog[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   rsp_cnt = 0;
    int   vld_cnt = 0;
    int   dis_grants = 0;
    int   peak = 0;
    bit   log_en = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Scoreboard monitor: push on handshake, pop/compare when a result is due.
    always @(negedge CLK) begin
        if (!RST) begin
            checks++;
            if ($countones(REQ_READY) > 1) begin
                errors++;
                $display("FAIL ready_onehot: got %b required at most one bit", REQ_READY);
            end
            for (int i = 0; i < int'(NREQ); i++) begin
                if (REQ_VALID[i] && REQ_READY[i]) begin
                    e_new.id   = IDW'(i);
                    e_new.data = fake_enc(REQ_STATE[128*i +: 128], REQ_KEY[256*i +: 256]);
                    e_new.due  = cyc + int'(LAT) + 1;
                    sbq.push_back(e_new);
                    if (log_en) glog.push_back(i);
                    if (!ENABLE) dis_grants++;
                end
            end
            if (RSP_VALID) vld_cnt++;
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                e_cur = sbq.pop_front();
                checks++;
                if (!RSP_VALID) begin
                    errors++;
                    $display("FAIL rsp_missing: cycle %0d got RSP_VALID=0 required 1 (id %0d)", cyc, e_cur.id);
                end else if (RSP_ID !== e_cur.id || RSP_DATA !== e_cur.data) begin
                    errors++;
                    $display("FAIL rsp_data: cycle %0d got id=%0d data=%h required id=%0d data=%h",
                             cyc, RSP_ID, RSP_DATA, e_cur.id, e_cur.data);
                end else begin
                    rsp_cnt++;
                end
            end else if (RSP_VALID) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: cycle %0d got RSP_VALID=1 id=%0d required 0", cyc, RSP_ID);
            end
            if (int'(IN_FLIGHT) > peak) peak = int'(IN_FLIGHT);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic rand_data();
        for (int i = 0; i < int'(NREQ); i++) begin
            REQ_STATE[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
            REQ_KEY[256*i +: 256]   = {$urandom, $urandom, $urandom, $urandom,
                                       $urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic do_reset();
        tick();
        RST = 1'b1;
        ENABLE = 1'b0;
        REQ_VALID = '0;
        #1;
        chk("rst_aes_state", AES_STATE, '0);
        chk("rst_aes_key", AES_KEY, '0);
        chk("rst_rsp_valid", RSP_VALID, 0);
        chk("rst_rsp_id", RSP_ID, 0);
        chk("rst_in_flight", IN_FLIGHT, 0);
        chk("rst_idle", IDLE, 1);
        chk("rst_ready", REQ_READY, 0);
        tick();
        tick();
        sbq.delete();
        RST = 1'b0;
    endtask

    task automatic start_run();
        ENABLE = 1'b1;
        REQ_VALID = '0;
        tick();
        chk("run_idle", IDLE, 0);
    endtask

    task automatic wait_drain(input string name, input int bound);
        for (int n = 0; n < bound; n++) begin
            if (sbq.size() == 0 && IN_FLIGHT == '0) break;
            tick();
        end
        chk(name, (sbq.size() == 0 && IN_FLIGHT == '0), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [10];
        int   r0, bad;
        int   gc [NREQ];

        RST = 1'b1; ENABLE = 1'b0; REQ_VALID = '0; REQ_STATE = '0; REQ_KEY = '0;
        do_reset();

        // Arbitration table from reset pointer (requester 0 first).
        tbl[0] = '{4'b1111, 4'b0001};
        tbl[1] = '{4'b1111, 4'b0010};
        tbl[2] = '{4'b0101, 4'b0100};
        tbl[3] = '{4'b0101, 4'b0001};
        tbl[4] = '{4'b1000, 4'b1000};
        tbl[5] = '{4'b0000, 4'b0000};
        tbl[6] = '{4'b0110, 4'b0010};
        tbl[7] = '{4'b0011, 4'b0001};
        tbl[8] = '{4'b0001, 4'b0001};
        tbl[9] = '{4'b1010, 4'b0010};
        start_run();
        for (int k = 0; k < 10; k++) begin
            rand_data();
            REQ_VALID = tbl[k].mask;
            #1;
            chk($sformatf("rr_vec%0d", k), REQ_READY, tbl[k].grant);
            tick();
        end
        REQ_VALID = '0;
        wait_drain("table_drain", 300);

        // Single block with the reference plaintext/key on requester 0.
        r0 = rsp_cnt;
        REQ_STATE[127:0] = 128'h00112233445566778899aabbccddeeff;
        REQ_KEY[255:0]   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        REQ_VALID = 4'b0001;
        #1;
        chk("single_grant", REQ_READY, 4'b0001);
        tick();
        REQ_VALID = '0;
        wait_drain("single_drain", 200);
        chk("single_rsp", rsp_cnt - r0, 1);

        // Fairness: all requesters valid for 40 cycles.
        do_reset();
        start_run();
        glog.delete();
        peak = 0;
        log_en = 1'b1;
        r0 = rsp_cnt;
        for (int n = 0; n < 40; n++) begin
            rand_data();
            REQ_VALID = 4'b1111;
            tick();
        end
        REQ_VALID = '0;
        log_en = 1'b0;
        chk("fair_count", glog.size(), 40);
        bad = 0;
        for (int i = 0; i < int'(NREQ); i++) gc[i] = 0;
        for (int i = 0; i < glog.size(); i++) begin
            if (glog[i] != i % int'(NREQ)) bad++;
            gc[glog[i]]++;
        end
        chk("fair_order", bad, 0);
        for (int i = 0; i < int'(NREQ); i++) chk($sformatf("fair_req%0d", i), gc[i], 10);
        wait_drain("fair_drain", 300);
        chk("fair_peak", peak, 40);
        chk("fair_rsp", rsp_cnt - r0, 40);

        // Drain: stream on requester 2, drop ENABLE mid-stream, keep requesting.
        r0 = rsp_cnt;
        dis_grants = 0;
        for (int n = 0; n < 60; n++) begin
            rand_data();
            REQ_VALID = 4'b0100;
            if (n == 30) ENABLE = 1'b0;
            tick();
        end
        chk("drain_not_idle", IDLE, 0);
        wait_drain("drain_empty", 300);
        tick();
        chk("drain_idle", IDLE, 1);
        chk("drain_no_grant", dis_grants, 0);
        chk("drain_rsp", rsp_cnt - r0, 30);
        REQ_VALID = '0;

        // Bubbles: requester 1 valid every third cycle.
        start_run();
        r0 = rsp_cnt;
        for (int n = 0; n < 30; n++) begin
            rand_data();
            REQ_VALID = (n % 3 == 0) ? 4'b0010 : 4'b0000;
            tick();
        end
        REQ_VALID = '0;
        wait_drain("bubble_drain", 300);
        chk("bubble_rsp", rsp_cnt - r0, 10);

        // Reset with 20 blocks in flight.
        for (int n = 0; n < 20; n++) begin
            rand_data();
            REQ_VALID = 4'b1000;
            tick();
        end
        chk("mid_inflight", IN_FLIGHT, 20);
        do_reset();
        r0 = vld_cnt;
        for (int n = 0; n < 120; n++) tick();
        chk("rst_no_rsp", vld_cnt - r0, 0);
        start_run();
        rand_data();
        REQ_VALID = 4'b1111;
        #1;
        chk("rst_first_grant", REQ_READY, 4'b0001);
        tick();
        REQ_VALID = '0;
        wait_drain("rst_drain", 300);

        // Re-enable while draining.
        r0 = rsp_cnt;
        for (int n = 0; n < 20; n++) begin
            rand_data();
            REQ_VALID = 4'b0010;
            if (n == 8)  ENABLE = 1'b0;
            if (n == 13) ENABLE = 1'b1;
            #1;
            if (n == 13) chk("reen_same_cycle", REQ_READY, 4'b0000);
            if (n == 14) chk("reen_next_cycle", REQ_READY, 4'b0010);
            tick();
        end
        REQ_VALID = '0;
        wait_drain("reen_drain", 300);
        chk("reen_rsp", rsp_cnt - r0, 14);
        chk("sb_empty", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
